// File: rtl/pwm_timer_core.sv
// Multi-channel PWM timebase with prescaler, edge/centre-aligned counting and
// double-buffered period/duty registers.
module pwm_timer_core #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 12
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               en,
  input  logic                                               mode,
  input  logic [PRESCALE_W-1:0]                              prescale,
  input  logic                                               period_wr,
  input  logic [WIDTH-1:0]                                   period_in,
  input  logic                                               duty_wr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] duty_ch,
  input  logic [WIDTH-1:0]                                   duty_in,
  output logic [WIDTH-1:0]                                   count,
  output logic                                               dir,
  output logic                                               period_evt,
  output logic [CHANNELS-1:0]                                pwm_out
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PRESCALE_W-1:0] pcnt;
  logic [WIDTH-1:0]      period_sh;
  logic [WIDTH-1:0]      period_act;
  logic [WIDTH-1:0]      duty_sh  [CHANNELS];
  logic [WIDTH-1:0]      duty_act [CHANNELS];
  logic                  mode_act;

  logic                  tick;
  logic                  ch_ok;
  logic [WIDTH-1:0]      count_next;
  logic                  dir_next;
  logic                  evt_next;
  logic [WIDTH-1:0]      period_next;
  logic                  mode_next;
  logic [WIDTH-1:0]      duty_next [CHANNELS];
  logic [CHANNELS-1:0]   pwm_next;

  assign tick  = (pcnt == prescale);
  assign ch_ok = (32'(duty_ch) < CHANNELS);

  // Counter next-state; period_sh is what period_act becomes at an event,
  // so the centre-aligned turn-around uses it to decide whether to step to 1.
  always_comb begin
    count_next = count;
    dir_next   = dir;
    evt_next   = 1'b0;
    if (tick) begin
      if (!mode_act) begin
        dir_next = 1'b1;
        if (count >= period_act) begin
          count_next = '0;
          evt_next   = 1'b1;
        end else begin
          count_next = count + WIDTH'(1);
        end
      end else if (dir) begin
        if (period_act == '0) begin
          count_next = '0;
          evt_next   = 1'b1;
        end else if (count >= period_act) begin
          dir_next   = 1'b0;
          count_next = period_act - WIDTH'(1);
        end else begin
          count_next = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          dir_next   = 1'b1;
          evt_next   = 1'b1;
          count_next = (period_sh != '0) ? WIDTH'(1) : '0;
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
    end
  end

  // Active values after this edge; compares use them so pwm tracks count exactly.
  always_comb begin
    period_next = evt_next ? period_sh : period_act;
    mode_next   = evt_next ? mode : mode_act;
    pwm_next    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_next[i] = evt_next ? duty_sh[i] : duty_act[i];
      pwm_next[i]  = (count_next < duty_next[i]);
    end
  end

  // Shadow registers, written independently of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_sh <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
    end else begin
      if (period_wr) period_sh <= period_in;
      if (duty_wr && ch_ok) duty_sh[CH_W'(duty_ch)] <= duty_in;
    end
  end

  // Timebase, active registers and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt       <= '0;
      count      <= '0;
      dir        <= 1'b1;
      period_evt <= 1'b0;
      pwm_out    <= '0;
      period_act <= '0;
      mode_act   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= '0;
    end else if (!en) begin
      pcnt       <= '0;
      count      <= '0;
      dir        <= 1'b1;
      period_evt <= 1'b0;
      pwm_out    <= '0;
      period_act <= period_sh;
      mode_act   <= mode;
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_sh[i];
    end else begin
      pcnt       <= tick ? '0 : pcnt + PRESCALE_W'(1);
      count      <= count_next;
      dir        <= dir_next;
      period_evt <= evt_next;
      pwm_out    <= pwm_next;
      period_act <= period_next;
      mode_act   <= mode_next;
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_next[i];
    end
  end

endmodule

// File: tb/tb_pwm_timer_core.sv
// Directed bench for pwm_timer_core: reset, edge/centre-aligned counting,
// prescaler, double-buffered duty and out-of-range channel writes.
module tb_pwm_timer_core;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned CHANNELS   = 3;
  localparam int unsigned PRESCALE_W = 12;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  period_wr;
  logic [WIDTH-1:0]      period_in;
  logic                  duty_wr;
  logic [1:0]            duty_ch;
  logic [WIDTH-1:0]      duty_in;
  logic [WIDTH-1:0]      count;
  logic                  dir;
  logic                  period_evt;
  logic [CHANNELS-1:0]   pwm_out;

  int checks = 0;
  int errors = 0;

  pwm_timer_core #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .prescale(prescale),
    .period_wr(period_wr), .period_in(period_in),
    .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_in(duty_in),
    .count(count), .dir(dir), .period_evt(period_evt), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_period(input logic [WIDTH-1:0] v);
    period_wr = 1'b1; period_in = v;
    step();
    period_wr = 1'b0;
  endtask

  task automatic wr_duty(input logic [1:0] ch, input logic [WIDTH-1:0] v);
    duty_wr = 1'b1; duty_ch = ch; duty_in = v;
    step();
    duty_wr = 1'b0;
  endtask

  task automatic wait_evt(input string tag);
    int n = 0;
    step();
    while (!period_evt && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_evt_seen"}, 32'(period_evt), 32'd1);
  endtask

  // One mode-0 period of 10 clk (period 9, prescale 0) starting at an event
  // sample; optional duty write issued at sample wr_at.
  task automatic check_period(input string tag, input int d0, input int d1, input int d2,
                              input int wr_at, input logic [1:0] wr_ch,
                              input logic [WIDTH-1:0] wr_val);
    int highs = 0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_count_%0d", tag, k), 32'(count), 32'(k));
      chk($sformatf("%s_evt_%0d", tag, k), 32'(period_evt), (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_pwm0_%0d", tag, k), 32'(pwm_out[0]), (k < d0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_pwm1_%0d", tag, k), 32'(pwm_out[1]), (k < d1) ? 32'd1 : 32'd0);
      chk($sformatf("%s_pwm2_%0d", tag, k), 32'(pwm_out[2]), (k < d2) ? 32'd1 : 32'd0);
      if (pwm_out[0]) highs++;
      if (k == wr_at) begin
        duty_wr = 1'b1; duty_ch = wr_ch; duty_in = wr_val;
      end
      step();
      duty_wr = 1'b0;
    end
    chk({tag, "_highs0"}, 32'(highs), 32'((d0 > 10) ? 10 : d0));
    chk({tag, "_next_evt"}, 32'(period_evt), 32'd1);
  endtask

  initial begin
    int highs;
    rst = 1'b0; en = 1'b0; mode = 1'b0; prescale = '0;
    period_wr = 1'b0; period_in = '0; duty_wr = 1'b0; duty_ch = '0; duty_in = '0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_evt", 32'(period_evt), 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);

    // T1: asynchronous reset in the middle of a long period
    rst = 1'b1;
    wr_period(8'd50);
    wr_duty(2'd0, 8'd40);
    en = 1'b1;
    wait_evt("t1");
    repeat (37) step();
    chk("t1_count37", 32'(count), 32'd37);
    chk("t1_pwm0_hi", 32'(pwm_out[0]), 32'd1);
    #2 rst = 1'b0; en = 1'b0;
    #1;
    chk("t1_async_count", 32'(count), 32'd0);
    chk("t1_async_pwm", 32'(pwm_out), 32'd0);
    chk("t1_async_dir", 32'(dir), 32'd1);
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("t1_en0_count", 32'(count), 32'd0);
    chk("t1_en0_pwm", 32'(pwm_out), 32'd0);
    chk("t1_en0_evt", 32'(period_evt), 32'd0);

    // T2/T6: edge-aligned, duty0=3, duty1 above period, duty2 zero
    wr_period(8'd9);
    wr_duty(2'd0, 8'd3);
    wr_duty(2'd1, 8'd10);
    wr_duty(2'd2, 8'd0);
    step();
    en = 1'b1;
    wait_evt("t2");
    check_period("t2a", 3, 10, 0, -1, 2'd0, 8'd0);
    // T5: mid-period write is held back until the boundary
    check_period("t5a", 3, 10, 0, 4, 2'd0, 8'd7);
    // Write coincident with the load: active keeps the pre-write shadow
    check_period("t5b", 7, 10, 0, 9, 2'd0, 8'd5);
    check_period("t5c", 7, 10, 0, -1, 2'd0, 8'd0);
    check_period("t5d", 5, 10, 0, -1, 2'd0, 8'd0);
    // T6: write to a channel index beyond the last channel is dropped
    check_period("t6a", 5, 10, 0, 4, 2'd3, 8'd1);
    check_period("t6b", 5, 10, 0, -1, 2'd0, 8'd0);

    // T3: prescale 2, period 4 -> count steps every 3 clk, event every 15 clk
    wr_period(8'd4);
    prescale = 12'd2;
    wait_evt("t3");
    for (int j = 0; j < 15; j++) begin
      chk($sformatf("t3_count_%0d", j), 32'(count), 32'(j / 3));
      chk($sformatf("t3_evt_%0d", j), 32'(period_evt), (j == 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("t3_next_evt", 32'(period_evt), 32'd1);
    chk("t3_next_count", 32'(count), 32'd0);

    // T4: centre-aligned, period 4, duty1=2
    prescale = 12'd0;
    wr_duty(2'd1, 8'd2);
    mode = 1'b1;
    wait_evt("t4_switch");
    wait_evt("t4");
    highs = 0;
    for (int j = 0; j < 8; j++) begin
      int exp_cnt;
      exp_cnt = (j <= 3) ? j + 1 : 7 - j;
      chk($sformatf("t4_count_%0d", j), 32'(count), 32'(exp_cnt));
      chk($sformatf("t4_dir_%0d", j), 32'(dir), (j <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("t4_evt_%0d", j), 32'(period_evt), (j == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t4_pwm1_%0d", j), 32'(pwm_out[1]), (exp_cnt < 2) ? 32'd1 : 32'd0);
      if (pwm_out[1]) highs++;
      step();
    end
    chk("t4_highs1", 32'(highs), 32'd3);
    chk("t4_next_evt", 32'(period_evt), 32'd1);
    chk("t4_next_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
